// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM-stage sequencer. Non-memory instructions pass straight
//               through to the MEM/WB register inputs. Loads and stores run a
//               req/ack transaction against a variable-latency data memory,
//               stalling the front of the pipeline and feeding bubbles into
//               MEM/WB (which captures every cycle) until the access ends.
//               An access that is not acknowledged within TIMEOUT busy cycles
//               is abandoned and flagged on the sticky ERR output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
   parameter int AWL     = 6,
   parameter int DWL     = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   // EX/MEM register outputs
   input  logic             RegWriteM,
   input  logic             MemtoRegM,
   input  logic             MemWriteM,
   input  logic [DWL-1:0]   ALUOutM,
   input  logic [DWL-1:0]   WriteDataM,
   input  logic [AWL-2:0]   WriteRegM,
   // data memory
   input  logic             MACK,
   input  logic [DWL-1:0]   MRDATA,
   output logic             MREQ,
   output logic             MWE,
   output logic [DWL-1:0]   MADDR,
   output logic [DWL-1:0]   MWDATA,
   // pipeline control
   output logic             STALL,
   // MEM/WB register inputs
   output logic             RegWriteW_D,
   output logic             MemtoRegW_D,
   output logic [DWL-1:0]   ALUOutW_D,
   output logic [DWL-1:0]   ReadDataW_D,
   output logic [AWL-2:0]   WriteRegW_D,
   // sticky timeout flag
   output logic             ERR
);

   // Counter only needs to reach TIMEOUT-1.
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_BUSY = 2'd1;
   localparam logic [1:0] C_DONE = 2'd2;

   logic [1:0]     r_state;
   logic [CW-1:0]  r_cnt;
   logic           r_load;
   logic [DWL-1:0] r_rdata;
   logic           r_err;
   logic           r_mreq;
   logic           r_mwe;
   logic [DWL-1:0] r_maddr;
   logic [DWL-1:0] r_mwdata;

   logic           w_memop;
   logic           w_stall;
   logic           w_busy;
   logic           w_ack;
   logic           w_tmo;

   assign w_memop = MemtoRegM | MemWriteM;
   assign w_busy  = (r_state == C_BUSY);
   // An ack always wins over a timeout landing in the same cycle.
   assign w_ack   = w_busy & MACK;
   assign w_tmo   = w_busy & ~MACK & (r_cnt == C_TMO_LAST);

   // Sequencer state, memory request registers and busy-cycle counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= C_IDLE;
         r_cnt    <= '0;
         r_load   <= 1'b0;
         r_mreq   <= 1'b0;
         r_mwe    <= 1'b0;
         r_maddr  <= '0;
         r_mwdata <= '0;
      end else begin
         case (r_state)
            C_IDLE: begin
               if (w_memop) begin
                  r_mreq   <= 1'b1;
                  r_mwe    <= MemWriteM;
                  r_maddr  <= ALUOutM;
                  r_mwdata <= WriteDataM;
                  // A load+store combination is treated as a store: no capture.
                  r_load   <= MemtoRegM & ~MemWriteM;
                  r_cnt    <= '0;
                  r_state  <= C_BUSY;
               end
            end
            C_BUSY: begin
               r_cnt <= r_cnt + CW'(1);
               if (w_ack || w_tmo) begin
                  r_mreq  <= 1'b0;
                  r_state <= C_DONE;
               end
            end
            C_DONE: begin
               r_state <= C_IDLE;
            end
            default: begin
               r_mreq  <= 1'b0;
               r_state <= C_IDLE;
            end
         endcase
      end
   end

   // Read-data capture on ack (loads only) and sticky error on timeout.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_ack) begin
         if (r_load) begin
            r_rdata <= MRDATA;
         end
      end else if (w_tmo) begin
         r_rdata <= '0;
         r_err   <= 1'b1;
      end
   end

   // Stall while a memory op is detected in IDLE or the access is in flight.
   always_comb begin
      w_stall = 1'b0;
      if (RST_N) begin
         case (r_state)
            C_IDLE:  w_stall = w_memop;
            C_BUSY:  w_stall = 1'b1;
            default: w_stall = 1'b0;
         endcase
      end
   end

   assign MREQ   = r_mreq;
   assign MWE    = r_mwe;
   assign MADDR  = r_maddr;
   assign MWDATA = r_mwdata;
   assign STALL  = w_stall;
   assign ERR    = r_err;

   // While stalled the write enable is masked so MEM/WB captures a bubble.
   assign RegWriteW_D = RegWriteM & ~w_stall & RST_N;
   assign MemtoRegW_D = MemtoRegM;
   assign ALUOutW_D   = ALUOutM;
   assign ReadDataW_D = r_rdata;
   assign WriteRegW_D = WriteRegM;

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage sequencer of the pipelined core; sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Non-memory instructions pass through combinationally.
- Loads and stores run a req/ack transaction to a variable-latency data memory and stall the front of the pipeline until it completes.
- The MEM/WB register has no enable and captures every cycle, so this block inserts bubbles into it while stalled.
- Its outputs drive the MEM/WB register inputs directly: RegWrite, MemtoReg, ALUOut, ReadData, WriteReg.

Parameters:
- AWL, 6, address width; the register specifier is AWL-1 bits.
- DWL, 32, data word width.
- TIMEOUT, 16, maximum BUSY cycles before the access is abandoned (must be ≥2).

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- RegWriteM  in  1  register-write control from EX/MEM.
- MemtoRegM  in  1  load indicator from EX/MEM.
- MemWriteM  in  1  store indicator from EX/MEM.
- ALUOutM  in  DWL  ALU result; this is the memory address for loads and stores.
- WriteDataM  in  DWL  store data.
- WriteRegM  in  AWL-1  destination register.
- MACK  in  1  memory acknowledge; read data is valid on MRDATA in the same cycle.
- MRDATA  in  DWL  memory read data.
- MREQ  out  1  memory request, registered.
- MWE  out  1  memory write enable, registered.
- MADDR  out  DWL  memory address, registered.
- MWDATA  out  DWL  memory write data, registered.
- STALL  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- RegWriteW_D  out  1  to MEM/WB D1.
- MemtoRegW_D  out  1  to MEM/WB D2.
- ALUOutW_D  out  DWL  to MEM/WB D3.
- ReadDataW_D  out  DWL  to MEM/WB D4.
- WriteRegW_D  out  AWL-1  to MEM/WB D5.
- ERR  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state=IDLE; MREQ=0, MWE=0, MADDR=0, MWDATA=0.
  - Read-data register=0, timeout counter=0, ERR=0.
  - STALL=0; RegWriteW_D forced 0.
- Reset mid-transaction: MREQ drops immediately and the access is abandoned. Any MACK arriving after release is ignored.
- memop = MemtoRegM | MemWriteM.
- IDLE:
  - memop=0: STALL=0. All *_D outputs pass through from the M inputs; ReadDataW_D=MRDATA-capture register (don't-care for non-loads).
  - memop=1: STALL=1 and RegWriteW_D=0 (bubble). Register MREQ=1, MWE=MemWriteM, MADDR=ALUOutM, MWDATA=WriteDataM. Clear the counter and go to BUSY.
- BUSY:
  - STALL=1, RegWriteW_D=0; MREQ/MWE/MADDR/MWDATA held stable; counter increments each cycle.
  - MACK=1: capture MRDATA (loads only; stores leave the register unchanged), MREQ←0, go to DONE.
  - MACK=0 and counter=TIMEOUT-1: ERR←1, read-data register←0, MREQ←0, go to DONE.
  - MACK and timeout in the same cycle: MACK wins and ERR is unchanged.
- DONE (exactly one cycle):
  - STALL=0. *_D outputs pass through from the still-held EX/MEM values; ReadDataW_D=captured data.
  - MEM/WB captures the completed instruction at the next edge; go to IDLE.
- Back-to-back memory ops: a memop seen in IDLE immediately after DONE starts a new transaction; no extra idle cycle is required.
- MACK outside BUSY is ignored.
- Minimum memory-op cost: 3 cycles (IDLE detect, BUSY with same-cycle ack, DONE), of which STALL is high for 2. A non-memory op costs 1 cycle with no stall.
- ERR stays 1 until reset; the pipeline continues after a timeout.
- MemWriteM and MemtoRegM both 1 is illegal. The block treats it as a store (MWE=1) and no data capture occurs.

Test Plan:
- Reset-then-ALU op: RST_N low mid-cycle → MREQ=0, STALL=0, ERR=0 asynchronously. Then RegWriteM=1, ALUOutM=0x0000_0010, WriteRegM=5 → same-cycle RegWriteW_D=1, ALUOutW_D=0x10, WriteRegW_D=5, STALL=0.
- Load with 0-wait ack:
  - Stimulus: MemtoRegM=1, RegWriteM=1, ALUOutM=0x40; memory acks on the first MREQ cycle with MRDATA=0xCAFE_F00D.
  - Required: STALL=1 for 2 cycles; MADDR=0x40, MWE=0; RegWriteW_D=0 during the stall. In DONE: RegWriteW_D=1, ReadDataW_D=0xCAFE_F00D.
- Store with 3-cycle ack latency: MemWriteM=1, ALUOutM=0x80, WriteDataM=0x1234_5678 → MWE=1, MADDR/MWDATA stable across 3 BUSY cycles; STALL high 4 cycles; ERR=0.
- Timeout with TIMEOUT=4 and MACK never asserted → MREQ high exactly 4 cycles; ERR=1 and sticky; ReadDataW_D=0 in DONE; the next ALU op flows normally.
- Simultaneous events: MACK on the final timeout cycle → data captured, ERR=0. Stray MACK in IDLE → no effect.
- Reset in BUSY: RST_N low during the 2nd BUSY cycle → MREQ=0 immediately. After release, state=IDLE and a late MACK is ignored.
